// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmitter between N_REQ byte sources.
// It takes one byte per valid/ack handshake and follows tx_ready through each frame.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ID_W           = 2,
  parameter int ACCEPT_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int CNT_W = (ACCEPT_TIMEOUT > 2) ? $clog2(ACCEPT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [ID_W:0]    N_WRAP   = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  state_t               state_r;
  state_t               state_nx_s;
  logic [ID_W-1:0]      rr_ptr_r;
  logic [ID_W-1:0]      rr_ptr_nx_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nx_s;
  logic [N_REQ-1:0]     ack_nx_s;
  logic                 start_nx_s;
  logic                 done_nx_s;
  logic                 err_nx_s;
  logic [7:0]           data_nx_s;
  logic [ID_W-1:0]      grant_nx_s;

  logic                 win_found_s;
  logic [ID_W-1:0]      win_idx_s;
  logic [ID_W:0]        cand_sum_s;
  logic [ID_W-1:0]      cand_s;
  logic                 cand_hit_s;

  // Winner search: first valid requester at or after rr_ptr, wrapping past N_REQ-1.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_sum_s  = '0;
    cand_s      = '0;
    cand_hit_s  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_sum_s  = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
      cand_sum_s  = (cand_sum_s >= N_WRAP) ? (cand_sum_s - N_WRAP) : cand_sum_s;
      cand_s      = cand_sum_s[ID_W-1:0];
      cand_hit_s  = !win_found_s && req_valid[cand_s];
      win_idx_s   = cand_hit_s ? cand_s : win_idx_s;
      win_found_s = win_found_s | cand_hit_s;
    end
  end

  // Next-state and next-output logic; every output below is registered.
  always_comb begin
    state_nx_s  = state_r;
    rr_ptr_nx_s = rr_ptr_r;
    cnt_nx_s    = cnt_r;
    ack_nx_s    = '0;
    start_nx_s  = 1'b0;
    done_nx_s   = 1'b0;
    err_nx_s    = 1'b0;
    data_nx_s   = tx_data;
    grant_nx_s  = grant_id;
    case (state_r)
      IDLE: begin
        if (tx_ready && win_found_s) begin
          data_nx_s   = req_data[{win_idx_s, 3'b000} +: 8];
          grant_nx_s  = win_idx_s;
          ack_nx_s    = N_REQ'(1) << win_idx_s;
          rr_ptr_nx_s = (win_idx_s == ID_LAST) ? '0 : (win_idx_s + ID_W'(1));
          state_nx_s  = START;
        end else begin
          state_nx_s  = IDLE;
        end
      end
      START: begin
        start_nx_s = 1'b1;
        cnt_nx_s   = '0;
        state_nx_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_ready) begin
          state_nx_s = WAIT_DONE;
        end else if (cnt_r == CNT_LAST) begin
          // Transmitter never took the byte: drop it and report.
          err_nx_s   = 1'b1;
          state_nx_s = IDLE;
        end else begin
          cnt_nx_s   = cnt_r + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          done_nx_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = WAIT_DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      cnt_r    <= '0;
      req_ack  <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      rr_ptr_r <= rr_ptr_nx_s;
      cnt_r    <= cnt_nx_s;
      req_ack  <= ack_nx_s;
      tx_start <= start_nx_s;
      tx_data  <= data_nx_s;
      grant_id <= grant_nx_s;
      busy     <= (state_nx_s != IDLE);
      done     <= done_nx_s;
      err      <= err_nx_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small 8N1 transmitter model (4 clk/bit).
// Event monitors log acks, starts, done and err pulses; tests compare them to hand-derived values.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        done;
  logic        err;

  logic        force_en = 1'b0;
  logic        force_val = 1'b0;
  logic        auto_drop = 1'b1;

  logic        uart_busy = 1'b0;
  logic [9:0]  uart_sh = 10'h3FF;
  logic [3:0]  uart_bit = 4'd0;
  logic [1:0]  uart_clk = 2'd0;
  logic        serial;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int onehot_viol = 0, overlap_viol = 0, data_viol = 0;
  int grant_log[$];
  int done_at_grant[$];
  logic [7:0] start_data[$];
  logic [7:0] prev_tx_data = 8'h00;

  uart_tx_arbiter #(.N_REQ(4), .ID_W(2), .ACCEPT_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign tx_ready = force_en ? force_val : !uart_busy;
  assign serial   = uart_busy ? uart_sh[0] : 1'b1;

  // Transmitter model: start bit, 8 data bits LSB first, stop bit, 4 clocks each.
  always @(posedge clk) begin
    if (!uart_busy) begin
      if (tx_start) begin
        uart_busy <= 1'b1;
        uart_sh   <= {1'b1, tx_data, 1'b0};
        uart_bit  <= 4'd0;
        uart_clk  <= 2'd0;
      end
    end else if (uart_clk == 2'd3) begin
      uart_clk <= 2'd0;
      if (uart_bit == 4'd9) begin
        uart_busy <= 1'b0;
      end else begin
        uart_bit <= uart_bit + 4'd1;
        uart_sh  <= uart_sh >> 1;
      end
    end else begin
      uart_clk <= uart_clk + 2'd1;
    end
  end

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|req_ack) begin
        ack_cnt++;
        for (int i = 0; i < 4; i++) if (req_ack[i]) grant_log.push_back(i);
        done_at_grant.push_back(done_cnt);
        if ($countones(req_ack) != 1) onehot_viol++;
        if (auto_drop) req_valid = req_valid & ~req_ack;
      end
      if (tx_start) begin
        start_cnt++;
        start_data.push_back(tx_data);
        if (|req_ack) overlap_viol++;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if ((tx_data != prev_tx_data) && (req_ack == 4'b0000)) data_viol++;
    end
    prev_tx_data = tx_data;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int get_cnt(input int sel);
    case (sel)
      0:       return ack_cnt;
      1:       return start_cnt;
      2:       return done_cnt;
      3:       return err_cnt;
      default: return 0;
    endcase
  endfunction

  task automatic wait_cnt(input string tag, input int sel, input int target, input int budget);
    int k = 0;
    while (get_cnt(sel) < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_val(tag, 32'(get_cnt(sel) >= target), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ack"},   32'(req_ack),  32'h0);
    check_val({tag, "_start"}, 32'(tx_start), 32'h0);
    check_val({tag, "_data"},  32'(tx_data),  32'h0);
    check_val({tag, "_gid"},   32'(grant_id), 32'h0);
    check_val({tag, "_busy"},  32'(busy),     32'h0);
    check_val({tag, "_done"},  32'(done),     32'h0);
    check_val({tag, "_err"},   32'(err),      32'h0);
  endtask

  logic [9:0] frame;
  logic [7:0] exp_b [4];
  int a0, s0, d0, e0, g0;

  initial begin
    exp_b = '{8'h10, 8'h21, 8'h32, 8'h43};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs("rst");

    // Single request from requester 2.
    req_data  = 32'h00A5_0000;
    d0 = done_cnt;
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    check_val("single_ack",     32'(req_ack),  32'h4);
    check_val("single_gid",     32'(grant_id), 32'h2);
    check_val("single_data",    32'(tx_data),  32'hA5);
    check_val("single_nostart", 32'(tx_start), 32'h0);
    @(negedge clk);
    check_val("single_start",   32'(tx_start), 32'h1);
    check_val("single_ack_off", 32'(req_ack),  32'h0);
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      repeat (2) @(negedge clk);
      frame[k] = serial;
      repeat (2) @(negedge clk);
    end
    check_val("single_frame", 32'(frame), 32'h34A);
    wait_cnt("single_done_wait", 2, d0 + 1, 20);
    repeat (3) @(posedge clk);
    check_val("single_done_once", 32'(done_cnt - d0), 32'd1);

    // rr_ptr should now be 3: with 0 and 3 pending, 3 wins.
    a0 = ack_cnt;
    d0 = done_cnt;
    req_valid = 4'b1001;
    wait_cnt("rr3_ack_wait", 0, a0 + 1, 10);
    req_valid = 4'b0000;
    check_val("rr3_grant", 32'(grant_log[grant_log.size()-1]), 32'd3);
    wait_cnt("rr3_done_wait", 2, d0 + 1, 80);

    // All four continuously valid.
    do_reset();
    auto_drop = 1'b0;
    req_data  = 32'h4332_2110;
    g0 = grant_log.size();
    s0 = start_cnt;
    a0 = ack_cnt;
    d0 = done_cnt;
    data_viol = 0;
    req_valid = 4'b1111;
    wait_cnt("rr_ack_wait", 0, a0 + 5, 400);
    req_valid = 4'b0000;
    auto_drop = 1'b1;
    for (int k = 0; k < 5; k++)
      check_val($sformatf("rr_order_%0d", k), 32'(grant_log[g0+k]), 32'(k % 4));
    check_val("rr_done_before_5th", 32'(done_at_grant[g0+4] - d0), 32'd4);
    wait_cnt("rr_start_wait", 1, s0 + 5, 10);
    for (int k = 0; k < 5; k++)
      check_val($sformatf("rr_data_%0d", k), 32'(start_data[s0+k]), 32'(exp_b[k % 4]));
    wait_cnt("rr_done_wait", 2, d0 + 5, 80);
    check_val("rr_data_stable", 32'(data_viol), 32'd0);

    // Withdrawal: requester 0 drops while frame for requester 1 is in flight.
    do_reset();
    req_data  = 32'h4433_2211;
    a0 = ack_cnt;
    d0 = done_cnt;
    req_valid = 4'b0001;
    wait_cnt("wd_first_ack", 0, a0 + 1, 10);
    wait_cnt("wd_first_done", 2, d0 + 1, 80);
    req_valid = 4'b0011;
    wait_cnt("wd_ack_wait", 0, a0 + 2, 10);
    check_val("wd_grant1", 32'(grant_log[grant_log.size()-1]), 32'd1);
    repeat (5) @(posedge clk);
    req_valid = 4'b0000;
    wait_cnt("wd_done_wait", 2, d0 + 2, 80);
    repeat (10) @(posedge clk);
    check_val("wd_no_more_ack", 32'(ack_cnt - a0), 32'd2);
    @(negedge clk);
    check_val("wd_idle", 32'(busy), 32'h0);

    // Accept timeout with tx_ready stuck high.
    do_reset();
    force_en  = 1'b1;
    force_val = 1'b1;
    a0 = ack_cnt; s0 = start_cnt; d0 = done_cnt; e0 = err_cnt;
    req_valid = 4'b0100;
    wait_cnt("to_err_wait", 3, e0 + 1, 40);
    repeat (20) @(posedge clk);
    check_val("to_ack",   32'(ack_cnt - a0),   32'd1);
    check_val("to_start", 32'(start_cnt - s0), 32'd1);
    check_val("to_err",   32'(err_cnt - e0),   32'd1);
    check_val("to_done",  32'(done_cnt - d0),  32'd0);
    @(negedge clk);
    check_val("to_idle",  32'(busy), 32'h0);
    force_en = 1'b0;
    repeat (60) @(posedge clk);

    // Reset during WAIT_DONE.
    do_reset();
    req_data = 32'h8800_0077;
    s0 = start_cnt;
    req_valid = 4'b0001;
    wait_cnt("rm_start_wait", 1, s0 + 1, 10);
    repeat (6) @(posedge clk);
    d0 = done_cnt; e0 = err_cnt;
    do_reset();
    check_reset_outputs("rm");
    repeat (60) @(posedge clk);
    check_val("rm_no_done", 32'(done_cnt - d0), 32'd0);
    check_val("rm_no_err",  32'(err_cnt - e0),  32'd0);
    a0 = ack_cnt;
    d0 = done_cnt;
    req_valid = 4'b1001;
    wait_cnt("rm_ack0_wait", 0, a0 + 1, 10);
    check_val("rm_grant0", 32'(grant_log[grant_log.size()-1]), 32'd0);
    wait_cnt("rm_ack3_wait", 0, a0 + 2, 100);
    check_val("rm_grant3", 32'(grant_log[grant_log.size()-1]), 32'd3);
    wait_cnt("rm_done_wait", 2, d0 + 2, 100);

    // Backpressure: tx_ready held low.
    repeat (5) @(posedge clk);
    force_en  = 1'b1;
    force_val = 1'b0;
    a0 = ack_cnt;
    d0 = done_cnt;
    req_valid = 4'b0001;
    repeat (10) @(posedge clk);
    check_val("bp_no_ack",  32'(ack_cnt - a0), 32'd0);
    @(negedge clk);
    check_val("bp_idle",    32'(busy), 32'h0);
    force_en = 1'b0;
    @(negedge clk);
    check_val("bp_ack",     32'(req_ack), 32'h1);
    wait_cnt("bp_done_wait", 2, d0 + 1, 80);

    check_val("ack_onehot",     32'(onehot_viol),  32'd0);
    check_val("ack_start_excl", 32'(overlap_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
